// File: rtl/time_display_scan.sv
// time_display_scan: 4-digit multiplexed 7-segment scanner; inputs snapshotted once per frame (blink gating under WINK_EN).
// Latency: Seg/Dp/Dig/Frame_Start registered 1 cycle after scan state; live inputs shown from the next frame boundary.
// Backpressure: none; free-running scan, En=0 blanks the display and restarts the frame on return.
module time_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       En,
    input  logic [3:0] A_Time_L,
    input  logic [3:0] A_Time_H,
    input  logic [3:0] B_Time_L,
    input  logic [3:0] B_Time_H,
    input  logic       A_Light,
    input  logic       B_Light,
    input  logic       Wink,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] Dig,
    output logic       Frame_Start,
    output logic       Bad_Digit
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          running;
    logic          loaded;

    logic [3:0]    sh_a_l, sh_a_h, sh_b_l, sh_b_h;
    logic          sh_a_light, sh_b_light, sh_wink;

    logic          wrap_digit;
    logic          load_now;
    logic          any_bad;
    logic          dark;

    logic [3:0]    cur;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    dig_n;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    assign wrap_digit = (cnt == CW'(SCAN_DIV - 1));
    // A snapshot arms the scan on the first enabled cycle, then refreshes at each frame wrap.
    assign load_now   = En && (!running || (wrap_digit && (idx == 2'd3)));
    assign any_bad    = (A_Time_L > 4'd9) || (A_Time_H > 4'd9) ||
                        (B_Time_L > 4'd9) || (B_Time_H > 4'd9);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt     <= '0;
            idx     <= 2'd0;
            running <= 1'b0;
        end else if (!En) begin
            cnt     <= '0;
            idx     <= 2'd0;
            running <= 1'b0;
        end else if (!running) begin
            cnt     <= '0;
            idx     <= 2'd0;
            running <= 1'b1;
        end else if (wrap_digit) begin
            cnt     <= '0;
            idx     <= idx + 2'd1;
        end else begin
            cnt     <= cnt + CW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sh_a_l     <= 4'd0;
            sh_a_h     <= 4'd0;
            sh_b_l     <= 4'd0;
            sh_b_h     <= 4'd0;
            sh_a_light <= 1'b0;
            sh_b_light <= 1'b0;
            sh_wink    <= 1'b0;
            loaded     <= 1'b0;
            Bad_Digit  <= 1'b0;
        end else begin
            loaded <= load_now;
            if (load_now) begin
                sh_a_l     <= A_Time_L;
                sh_a_h     <= A_Time_H;
                sh_b_l     <= B_Time_L;
                sh_b_h     <= B_Time_H;
                sh_a_light <= A_Light;
                sh_b_light <= B_Light;
                sh_wink    <= Wink;
                if (any_bad) begin
                    Bad_Digit <= 1'b1;
                end
            end
        end
    end

`ifdef WINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          phase_on;

    // Phase advances at the snapshot edge so a whole frame is shown in one phase;
    // the first Wink frame after a non-Wink frame always starts a fresh lit period.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (load_now) begin
            if (!Wink || !sh_wink) begin
                blink_cnt <= '0;
                phase_on  <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                phase_on  <= !phase_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign dark = sh_wink && !phase_on;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_wink;

    assign unused_wink = Wink;
    assign dark        = 1'b0;
`endif

    always_comb begin
        cur   = sh_a_l;
        seg_n = 7'h00;
        dp_n  = 1'b0;
        dig_n = 4'b0000;
        case (idx)
            2'd0:    cur = sh_a_l;
            2'd1:    cur = sh_a_h;
            2'd2:    cur = sh_b_l;
            default: cur = sh_b_h;
        endcase
        if (En && running) begin
            dig_n = 4'b0001 << idx;
            // High digits blank a leading zero; low digits always show.
            seg_n = (idx[0] && (cur == 4'd0)) ? 7'h00 : seg_decode(cur);
            dp_n  = ((idx == 2'd0) && sh_a_light) || ((idx == 2'd2) && sh_b_light);
            if (dark) begin
                seg_n = 7'h00;
                dp_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Seg         <= 7'h00;
            Dp          <= 1'b0;
            Dig         <= 4'b0000;
            Frame_Start <= 1'b0;
        end else begin
            Seg         <= seg_n;
            Dp          <= dp_n;
            Dig         <= dig_n;
            Frame_Start <= loaded;
        end
    end

    a_dig_onehot0: assert property (@(posedge Clk) disable iff (Rst) $onehot0(Dig));

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: directed stimulus, literal spot checks and a frame-arithmetic model compared every cycle.
module tb_time_display_scan;

    localparam int S  = 4;
    localparam int BF = 2;
`ifdef WINK_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       En = 1'b0;
    logic [3:0] A_Time_L = 4'd0, A_Time_H = 4'd0, B_Time_L = 4'd0, B_Time_H = 4'd0;
    logic       A_Light = 1'b0, B_Light = 1'b0, Wink = 1'b0;
    logic [6:0] Seg;
    logic       Dp;
    logic [3:0] Dig;
    logic       Frame_Start;
    logic       Bad_Digit;

    int vectors = 0;
    int miscompares = 0;

    time_display_scan #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
        .Clk(Clk), .Rst(Rst), .En(En),
        .A_Time_L(A_Time_L), .A_Time_H(A_Time_H), .B_Time_L(B_Time_L), .B_Time_H(B_Time_H),
        .A_Light(A_Light), .B_Light(B_Light), .Wink(Wink),
        .Seg(Seg), .Dp(Dp), .Dig(Dig), .Frame_Start(Frame_Start), .Bad_Digit(Bad_Digit)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
            4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
            4'd8: p = 7'h7F;  4'd9: p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    // Model: position in the frame is plain arithmetic on the edge count since the arming edge.
    int         edge_n = 0;
    int         start_edge = 0;
    int         wink_frame = 0;
    int         d;
    bit         run = 0, load_prev = 0, bad = 0, load;
    logic [3:0] m_al = 0, m_ah = 0, m_bl = 0, m_bh = 0, v;
    bit         m_alt = 0, m_blt = 0, m_wink = 0;
    logic [6:0] e_seg;
    logic       e_dp, e_fs, e_bad;
    logic [3:0] e_dig;

    always @(posedge Clk) begin
        edge_n++;
        if (Rst) begin
            run = 0; load_prev = 0; bad = 0; wink_frame = 0;
            m_al = 0; m_ah = 0; m_bl = 0; m_bh = 0; m_alt = 0; m_blt = 0; m_wink = 0;
            e_seg = 0; e_dp = 0; e_dig = 0; e_fs = 0; e_bad = 0;
        end else begin
            e_fs = load_prev; e_seg = 0; e_dp = 0; e_dig = 0;
            if (En && run) begin
                d = ((edge_n - 1 - start_edge) % (4 * S)) / S;
                e_dig = 4'(1 << d);
                case (d)
                    0: v = m_al;
                    1: v = m_ah;
                    2: v = m_bl;
                    default: v = m_bh;
                endcase
                e_seg = ((d % 2 == 1) && v == 4'd0) ? 7'h00 : pattern(v);
                e_dp  = (d == 0 && m_alt) || (d == 2 && m_blt);
                if (WE && m_wink && ((wink_frame / BF) % 2 == 1)) begin
                    e_seg = 0; e_dp = 0;
                end
            end
            load = 0;
            if (!En) run = 0;
            else if (!run) begin run = 1; start_edge = edge_n; load = 1; end
            else if ((edge_n - start_edge) % (4 * S) == 0) load = 1;
            if (load) begin
                if (A_Time_L > 9 || A_Time_H > 9 || B_Time_L > 9 || B_Time_H > 9) bad = 1;
                wink_frame = (Wink && m_wink) ? wink_frame + 1 : 0;
                m_al = A_Time_L; m_ah = A_Time_H; m_bl = B_Time_L; m_bh = B_Time_H;
                m_alt = A_Light; m_blt = B_Light; m_wink = Wink;
            end
            load_prev = load;
            e_bad = bad;
        end
        #1;
        vectors++;
        if ({Seg, Dp, Dig, Frame_Start, Bad_Digit} !== {e_seg, e_dp, e_dig, e_fs, e_bad}) begin
            miscompares++;
            $display("FAIL model edge %0d: Seg=%h/%h Dp=%b/%b Dig=%b/%b Frame_Start=%b/%b Bad_Digit=%b/%b (got/expected)",
                     edge_n, Seg, e_seg, Dp, e_dp, Dig, e_dig, Frame_Start, e_fs, Bad_Digit, e_bad);
        end
    end

    task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        A_Time_H = 4'd3; A_Time_L = 4'd7; B_Time_H = 4'd0; B_Time_L = 4'd5;
        go(3);
        check_lit("reset_seg", {1'b0, Seg}, 8'h00);
        check_lit("reset_dp", {7'b0, Dp}, 8'h00);
        check_lit("reset_dig", {4'b0, Dig}, 8'h00);
        check_lit("reset_fs", {7'b0, Frame_Start}, 8'h00);
        check_lit("reset_bad", {7'b0, Bad_Digit}, 8'h00);

        Rst = 1'b0; En = 1'b1;
        go(2);
        check_lit("f1_dig0", {4'b0, Dig}, 8'h01);
        check_lit("f1_seg_al7", {1'b0, Seg}, 8'h07);
        check_lit("f1_fs", {7'b0, Frame_Start}, 8'h01);
        go(1);
        check_lit("f1_fs_low", {7'b0, Frame_Start}, 8'h00);
        go(3);
        check_lit("f1_dig1", {4'b0, Dig}, 8'h02);
        check_lit("f1_seg_ah3", {1'b0, Seg}, 8'h4F);
        go(4);
        check_lit("f1_dig2", {4'b0, Dig}, 8'h04);
        check_lit("f1_seg_bl5", {1'b0, Seg}, 8'h6D);
        go(4);
        check_lit("f1_dig3", {4'b0, Dig}, 8'h08);
        check_lit("f1_seg_bh_blank", {1'b0, Seg}, 8'h00);
        go(4);
        check_lit("f2_dig0", {4'b0, Dig}, 8'h01);
        check_lit("f2_fs", {7'b0, Frame_Start}, 8'h01);

        go(8);
        check_lit("f2_dig2", {4'b0, Dig}, 8'h04);
        A_Time_L = 4'd2;
        go(8);
        check_lit("f3_seg_al2", {1'b0, Seg}, 8'h5B);
        check_lit("f3_fs", {7'b0, Frame_Start}, 8'h01);
        A_Light = 1'b1;

        go(16);
        check_lit("dp_dig0_on", {3'b0, Dp, Dig}, 8'h11);
        go(4);
        check_lit("dp_dig1_off", {3'b0, Dp, Dig}, 8'h02);
        go(4);
        check_lit("dp_dig2_off", {3'b0, Dp, Dig}, 8'h04);
        check_lit("bad_before", {7'b0, Bad_Digit}, 8'h00);
        B_Time_L = 4'hC;
        go(8);
        check_lit("bad_set", {7'b0, Bad_Digit}, 8'h01);
        B_Time_L = 4'd5;
        go(8);
        check_lit("bad_dig2", {4'b0, Dig}, 8'h04);
        check_lit("bad_seg_dash", {1'b0, Seg}, 8'h40);
        go(16);
        check_lit("bad_recov_seg", {1'b0, Seg}, 8'h6D);
        check_lit("bad_sticky", {7'b0, Bad_Digit}, 8'h01);

        Wink = 1'b1;
        go(8);
        check_lit("wink_f0_lit", {Dp, Seg}, 8'hDB);
        go(32);
        check_lit("wink_f2_dig", {4'b0, Dig}, 8'h01);
        check_lit("wink_f2", {Dp, Seg}, WE ? 8'h00 : 8'hDB);
        go(16);
        check_lit("wink_f3", {Dp, Seg}, WE ? 8'h00 : 8'hDB);
        go(16);
        check_lit("wink_f4_lit", {Dp, Seg}, 8'hDB);
        go(32);
        check_lit("wink_f6", {Dp, Seg}, WE ? 8'h00 : 8'hDB);
        Wink = 1'b0;
        go(16);
        check_lit("wink_off_lit", {Dp, Seg}, 8'hDB);
        check_lit("wink_off_dig", {4'b0, Dig}, 8'h01);

        go(8);
        check_lit("pre_rst_dig2", {4'b0, Dig}, 8'h04);
        go(2);
        Rst = 1'b1;
        #1;
        check_lit("async_rst_seg", {1'b0, Seg}, 8'h00);
        check_lit("async_rst_dig", {4'b0, Dig}, 8'h00);
        check_lit("async_rst_fs", {7'b0, Frame_Start}, 8'h00);
        check_lit("async_rst_bad", {7'b0, Bad_Digit}, 8'h00);
        go(1);
        Rst = 1'b0;
        go(2);
        check_lit("post_rst_dig0", {4'b0, Dig}, 8'h01);
        check_lit("post_rst_fs", {7'b0, Frame_Start}, 8'h01);
        check_lit("post_rst_seg", {1'b0, Seg}, 8'h5B);

        go(6);
        check_lit("en_drop_dig1", {4'b0, Dig}, 8'h02);
        En = 1'b0;
        go(1);
        check_lit("en_low_dig", {4'b0, Dig}, 8'h00);
        En = 1'b1;
        go(2);
        check_lit("en_back_dig0", {4'b0, Dig}, 8'h01);
        check_lit("en_back_fs", {7'b0, Frame_Start}, 8'h01);

        go(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
